// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: arbitration states and RAM geometry.
package ram_port_arbiter_pkg;

  localparam int unsigned RAM_ADDR_W = 9;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_H = 2'd1,
    OWN_C = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arb_fsm.sv
// Ownership FSM for the shared RAM port: round-robin between host and control
// unit, burst-limited unlocked tenures, lockable block transfers.
module ram_arb_fsm
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned max_burst = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_req,
  input  logic       h_lock,
  input  logic       c_req,
  input  logic       c_lock,
  output arb_state_t state,
  output logic       access,
  output logic       h_gnt,
  output logic       c_gnt
);

  localparam logic [7:0] BURST_LAST = 8'(max_burst - 1);

  arb_state_t next_state;
  arb_state_t last;
  arb_state_t other;
  logic [7:0] burst_cnt;
  logic       own_req;
  logic       oth_req;
  logic       own_lock;

  always_comb begin
    own_req    = 1'b0;
    oth_req    = 1'b0;
    own_lock   = 1'b0;
    other      = IDLE;
    next_state = state;
    case (state)
      OWN_H: begin
        own_req  = h_req;
        oth_req  = c_req;
        own_lock = h_lock;
        other    = OWN_C;
      end
      OWN_C: begin
        own_req  = c_req;
        oth_req  = h_req;
        own_lock = c_lock;
        other    = OWN_H;
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (h_req && c_req)
          next_state = (last == OWN_H) ? OWN_C : OWN_H;
        else if (h_req)
          next_state = OWN_H;
        else if (c_req)
          next_state = OWN_C;
      end
      default: begin
        // >= so a count that ran past the limit under lock still yields once unlocked
        if (!own_req)
          next_state = oth_req ? other : IDLE;
        else if (oth_req && !own_lock && burst_cnt >= BURST_LAST)
          next_state = other;
      end
    endcase
  end

  assign access = own_req;
  assign h_gnt  = (state == OWN_H);
  assign c_gnt  = (state == OWN_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= OWN_C;
      burst_cnt <= '0;
    end else begin
      state <= next_state;
      if (state != IDLE && next_state != state)
        last <= state;
      if (next_state != state)
        burst_cnt <= '0;
      else if (access && burst_cnt != '1)
        burst_cnt <= burst_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single synchronous RAM port between host loader and control unit;
// muxes the owner's request onto the RAM and steers read data back.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned data_w    = DATA_W,
  parameter int unsigned addr_w    = RAM_ADDR_W,
  parameter int unsigned max_burst = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_lock,
  input  logic              h_we,
  input  logic [addr_w-1:0] h_addr,
  input  logic [data_w-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  input  logic              c_req,
  input  logic              c_lock,
  input  logic              c_we,
  input  logic [addr_w-1:0] c_addr,
  input  logic [data_w-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [data_w-1:0] rdata,
  output logic [addr_w-1:0] ram_addr,
  output logic              ram_we,
  output logic [data_w-1:0] ram_wdata,
  input  logic [data_w-1:0] ram_rdata
);

  arb_state_t        state;
  logic              access;
  logic              rd_h;
  logic              rd_c;
  logic [data_w-1:0] rdata_q;

  ram_arb_fsm #(
    .max_burst(max_burst)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .h_req  (h_req),
    .h_lock (h_lock),
    .c_req  (c_req),
    .c_lock (c_lock),
    .state  (state),
    .access (access),
    .h_gnt  (h_gnt),
    .c_gnt  (c_gnt)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    rd_h      = 1'b0;
    rd_c      = 1'b0;
    case (state)
      OWN_H: begin
        ram_addr  = h_addr;
        ram_wdata = h_wdata;
        ram_we    = access & h_we;
        rd_h      = access & ~h_we;
      end
      OWN_C: begin
        ram_addr  = c_addr;
        ram_wdata = c_wdata;
        ram_we    = access & c_we;
        rd_c      = access & ~c_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      rdata_q  <= '0;
    end else begin
      h_rvalid <= rd_h;
      c_rvalid <= rd_c;
      if (h_rvalid || c_rvalid)
        rdata_q <= ram_rdata;
    end
  end

  // RAM data arrives in the rvalid cycle itself; pass it through, then hold it
  assign rdata = (h_rvalid || c_rvalid) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: tenure-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_ram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          h_req = 1'b0, h_lock = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          c_req = 1'b0, c_lock = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          h_gnt, h_rvalid, c_gnt, c_rvalid, ram_we;
  logic [DW-1:0] rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;

  int checks = 0;
  int failures = 0;

  ram_port_arbiter #(
    .data_w   (DW),
    .addr_w   (AW),
    .max_burst(MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .h_req    (h_req),
    .h_lock   (h_lock),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .c_req    (c_req),
    .c_lock   (c_lock),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM stand-in
  logic [DW-1:0] ram [512];
  initial for (int i = 0; i < 512; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: owner 0=none 1=host 2=cu, accesses used in the current tenure
  int            m_owner = 0;
  int            m_last = 2;
  int            m_used = 0;
  bit            m_ph = 0, m_pc = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] m_hold = '0;
  logic [DW-1:0] mmem [512];
  initial for (int i = 0; i < 512; i++) mmem[i] = '0;

  initial begin : compare
    bit            o_req, o_we, x_req, o_lock, acc;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    forever begin
      @(negedge clk);
      o_req   = (m_owner == 1) ? h_req   : (m_owner == 2) ? c_req   : 1'b0;
      o_we    = (m_owner == 1) ? h_we    : (m_owner == 2) ? c_we    : 1'b0;
      o_addr  = (m_owner == 1) ? h_addr  : (m_owner == 2) ? c_addr  : '0;
      o_wdata = (m_owner == 1) ? h_wdata : (m_owner == 2) ? c_wdata : '0;
      if (rst) begin
        chk("cmp_rst_h_gnt", h_gnt, 0);
        chk("cmp_rst_c_gnt", c_gnt, 0);
        chk("cmp_rst_rvalid", {h_rvalid, c_rvalid}, 0);
        chk("cmp_rst_rdata", rdata, 0);
        chk("cmp_rst_ram_we", ram_we, 0);
        chk("cmp_rst_ram_addr", ram_addr, 0);
        chk("cmp_rst_ram_wdata", ram_wdata, 0);
      end else begin
        chk("cmp_h_gnt", h_gnt, m_owner == 1);
        chk("cmp_c_gnt", c_gnt, m_owner == 2);
        chk("cmp_h_rvalid", h_rvalid, m_ph);
        chk("cmp_c_rvalid", c_rvalid, m_pc);
        chk("cmp_rdata", rdata, (m_ph || m_pc) ? m_pdata : m_hold);
        chk("cmp_ram_we", ram_we, o_req && o_we);
        chk("cmp_ram_addr", ram_addr, o_addr);
        chk("cmp_ram_wdata", ram_wdata, o_wdata);
      end
      @(posedge clk);
      if (rst) begin
        m_owner = 0; m_last = 2; m_used = 0;
        m_ph = 0; m_pc = 0; m_hold = '0;
      end else begin
        o_req  = (m_owner == 1) ? h_req  : (m_owner == 2) ? c_req  : 1'b0;
        o_we   = (m_owner == 1) ? h_we   : (m_owner == 2) ? c_we   : 1'b0;
        o_addr = (m_owner == 1) ? h_addr : (m_owner == 2) ? c_addr : '0;
        o_wdata = (m_owner == 1) ? h_wdata : (m_owner == 2) ? c_wdata : '0;
        x_req  = (m_owner == 1) ? c_req  : (m_owner == 2) ? h_req  : 1'b0;
        o_lock = (m_owner == 1) ? h_lock : (m_owner == 2) ? c_lock : 1'b0;
        acc = o_req;
        if (m_ph || m_pc) m_hold = m_pdata;
        m_ph = acc && (m_owner == 1) && !o_we;
        m_pc = acc && (m_owner == 2) && !o_we;
        if (acc && !o_we) m_pdata = mmem[o_addr];
        if (acc && o_we) mmem[o_addr] = o_wdata;
        if (m_owner == 0) begin
          if (h_req && c_req) m_owner = (m_last == 1) ? 2 : 1;
          else if (h_req) m_owner = 1;
          else if (c_req) m_owner = 2;
          m_used = 0;
        end else if (!o_req) begin
          m_last = m_owner;
          m_owner = x_req ? 3 - m_owner : 0;
          m_used = 0;
        end else begin
          m_used++;
          if (x_req && !o_lock && m_used >= int'(MB)) begin
            m_last = m_owner;
            m_owner = 3 - m_owner;
            m_used = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    h_req = 0; h_lock = 0; h_we = 0;
    c_req = 0; c_lock = 0; c_we = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  // Host streams 20 reads from 0x100.., control unit waits to do 3 reads
  task automatic stream(input bit lock, input int exp_run1, input string tag);
    int h_cnt, c_cnt, run1;
    bit run1_done, prev_h_acc, hacc, cacc;
    h_cnt = 0; c_cnt = 0; run1 = 0; run1_done = 0; prev_h_acc = 0;
    do_reset();
    h_we = 0; c_we = 0; c_addr = 9'h001; h_lock = lock;
    for (int k = 0; k < 200 && !(h_cnt == 20 && c_cnt == 3); k++) begin
      h_req  = (h_cnt < 20);
      c_req  = (c_cnt < 3);
      h_addr = 9'(256 + h_cnt);
      hacc = h_gnt && h_req;
      cacc = c_gnt && c_req;
      if (hacc) begin
        h_cnt++;
        if (!run1_done) run1++;
      end
      if (cacc) begin
        if (!run1_done) begin
          run1_done = 1;
          chk({tag, "_run1"}, run1, exp_run1);
          if (!lock) begin
            chk({tag, "_no_dead_cycle"}, prev_h_acc, 1);
            chk({tag, "_tail_h_rvalid"}, h_rvalid, 1);
            chk({tag, "_tail_c_rvalid"}, c_rvalid, 0);
            chk({tag, "_tail_rdata"}, rdata, 32'hCAFE_010F);
          end else begin
            chk({tag, "_host_done_first"}, h_cnt, 20);
          end
        end
        c_cnt++;
      end
      prev_h_acc = hacc;
      cyc();
    end
    chk({tag, "_host_total"}, h_cnt, 20);
    chk({tag, "_cu_total"}, c_cnt, 3);
    idle_all();
    cyc();
  endtask

  logic [AW-1:0] wa [4] = '{9'h000, 9'h001, 9'h1FF, 9'h10F};
  logic [DW-1:0] wd [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_01FF, 32'hCAFE_010F};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    cyc();
    cyc();
    chk("reset_h_gnt", h_gnt, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_ram_addr", ram_addr, 0);
    rst = 0;

    // Single host: writes then reads back
    h_req = 1; h_we = 1; h_addr = wa[0]; h_wdata = wd[0];
    cyc();
    chk("t1_h_gnt_latency", h_gnt, 1);
    chk("t1_c_gnt", c_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      h_we = 1; h_addr = wa[i]; h_wdata = wd[i];
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      h_we = 0; h_addr = wa[i];
      cyc();
      chk("t1_h_rvalid", h_rvalid, 1);
      chk("t1_rdata", rdata, wd[i]);
      chk("t1_c_gnt_idle", c_gnt, 0);
    end
    h_req = 0;
    cyc();
    chk("t1_release_gnt", h_gnt, 0);
    chk("t1_no_rvalid_after", h_rvalid, 0);

    // Tie-breaking and round-robin
    do_reset();
    h_req = 1; c_req = 1; h_addr = 9'h000; c_addr = 9'h001;
    cyc();
    chk("t2_tie_host_gnt", h_gnt, 1);
    chk("t2_tie_c_gnt", c_gnt, 0);
    cyc();
    h_req = 0;
    cyc();
    chk("t2_handover_c_gnt", c_gnt, 1);
    chk("t2_handover_h_gnt", h_gnt, 0);
    cyc();
    c_req = 0;
    cyc();
    chk("t2_idle", {h_gnt, c_gnt}, 0);
    h_req = 1; c_req = 1;
    cyc();
    chk("t2_rr_host_gnt", h_gnt, 1);
    chk("t2_rr_c_gnt", c_gnt, 0);
    idle_all();
    cyc();

    stream(1'b0, 16, "t3_unlocked");
    stream(1'b1, 20, "t4_locked");

    // Asynchronous reset in the middle of a write burst
    do_reset();
    h_req = 1; h_we = 1; h_addr = 9'h1F0; h_wdata = 32'hDEAD_0000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      h_addr = 9'(9'h1F0 + i); h_wdata = 32'hDEAD_0000 + i;
      cyc();
    end
    h_addr = 9'h1F3; h_wdata = 32'hDEAD_BEEF;
    #2;
    rst = 1;
    #1;
    chk("t6_h_gnt", h_gnt, 0);
    chk("t6_ram_we", ram_we, 0);
    chk("t6_ram_addr", ram_addr, 0);
    chk("t6_ram_wdata", ram_wdata, 0);
    chk("t6_rvalid", {h_rvalid, c_rvalid}, 0);
    chk("t6_rdata", rdata, 0);
    cyc();
    chk("t6_no_write", ram[9'h1F3], 0);
    chk("t6_prior_write", ram[9'h1F2], 32'hDEAD_0002);
    h_we = 0; c_req = 1;
    rst = 0;
    cyc();
    chk("t6_post_reset_tie_host", h_gnt, 1);
    chk("t6_post_reset_tie_c", c_gnt, 0);
    idle_all();
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
